// File: rtl/id_ex_stage.sv
// Instruction decode plus the ID/EX pipeline register, with load-use bubble insertion.
// Optional ID_PERF_CNT_EN adds stall_cnt / bubble_cnt performance counters.
module id_ex_stage #(
  parameter int PC_W = 8,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            id_stall,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic            idex_valid,
  output logic [7:0]      idex_ctrl,
  output logic [31:0]     idex_instr,
  output logic [PC_W-1:0] idex_pc,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rd
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [7:0]      ctrl_dec;
  logic [XLEN-1:0] imm_dec;
  logic            uses_rs1, uses_rs2, load_use, bubble_wr;

  logic            valid_d, valid_q;
  logic [7:0]      ctrl_d, ctrl_q;
  logic [31:0]     instr_d, instr_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [4:0]      rd_d, rd_q;

  assign id_rs1 = if_instr[19:15];
  assign id_rs2 = if_instr[24:20];

  always_comb begin
    ctrl_dec = 8'h00;
    imm_dec  = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (if_instr[6:0])
      OP_R: begin
        ctrl_dec = 8'h41;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD: begin
        ctrl_dec = (if_instr[6:0] == OP_I) ? 8'hE1 : 8'h8B;
        imm_dec  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl_dec = 8'h84;
        imm_dec  = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec = 8'h30;
        imm_dec  = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // ctrl_q[3] is MemRead: the instruction in ID/EX is a load whose data is not ready yet.
  assign load_use = if_valid & valid_q & ctrl_q[3] & (rd_q != 5'd0) &
                    ((uses_rs1 & (rd_q == id_rs1)) | (uses_rs2 & (rd_q == id_rs2)));
  assign id_stall  = ex_stall | (load_use & ~flush);
  assign bubble_wr = flush | (~ex_stall & load_use);

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    if (bubble_wr) begin
      valid_d = 1'b0;
      ctrl_d  = 8'h00;
      instr_d = '0;
      pc_d    = '0;
      imm_d   = '0;
      rd_d    = '0;
    end else if (!ex_stall) begin
      valid_d = if_valid;
      ctrl_d  = if_valid ? ctrl_dec : 8'h00;
      instr_d = if_instr;
      pc_d    = if_pc;
      imm_d   = imm_dec;
      rd_d    = if_instr[11:7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
    end
  end

  assign idex_valid = valid_q;
  assign idex_ctrl  = ctrl_q;
  assign idex_instr = instr_q;
  assign idex_pc    = pc_q;
  assign idex_imm   = imm_q;
  assign idex_rd    = rd_q;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, id_stall};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_wr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised + directed bench for id_ex_stage against a table-driven reference model.
module tb_id_ex_stage;
  localparam int PC_W = 8;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, if_valid, flush, ex_stall;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            id_stall, idex_valid;
  logic [4:0]      id_rs1, id_rs2, idex_rd;
  logic [7:0]      idex_ctrl;
  logic [31:0]     idex_instr;
  logic [PC_W-1:0] idex_pc;
  logic [XLEN-1:0] idex_imm;
`ifdef ID_PERF_CNT_EN
  logic [31:0]     stall_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad = 0;

  id_ex_stage #(.PC_W(PC_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_stall(ex_stall), .id_stall(id_stall), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .idex_valid(idex_valid), .idex_ctrl(idex_ctrl),
    .idex_instr(idex_instr), .idex_pc(idex_pc), .idex_imm(idex_imm), .idex_rd(idex_rd)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ready = 0, m_known = 0;
  bit          m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_instr, m_imm;
  logic [7:0]  m_pc;
  logic [4:0]  m_rd;
  int unsigned m_sc, m_bc;

  function automatic logic [7:0] f_ctrl(logic [31:0] i);
    case (i[6:0])
      7'h33: return 8'h41;
      7'h13: return 8'hE1;
      7'h03: return 8'h8B;
      7'h23: return 8'h84;
      7'h63: return 8'h30;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit f_u1(logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  endfunction

  function automatic bit f_u2(logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic [31:0] f_imm(logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'h13, 7'h03: begin
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit f_hazard();
    if (!(if_valid && m_valid && m_ctrl == 8'h8B && m_rd != 0)) return 0;
    return (f_u1(if_instr) && m_rd == if_instr[19:15]) ||
           (f_u2(if_instr) && m_rd == if_instr[24:20]);
  endfunction

  function automatic bit f_stall();
    return ex_stall || (f_hazard() && !flush);
  endfunction

  task automatic m_clear();
    m_valid = 0; m_ctrl = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_known = 1;
  endtask

  always @(posedge clk) begin
    bit hz, st;
    if (rst) begin
      m_clear();
      m_sc = 0; m_bc = 0;
      m_ready = 1;
    end else if (m_ready) begin
      hz = f_hazard();
      st = f_stall();
      if (st) m_sc++;
      if (flush) begin
        m_clear();
        m_bc++;
      end else if (ex_stall) begin
        // hold
      end else if (hz) begin
        m_valid = 0; m_ctrl = 0; m_known = 0;
        m_bc++;
      end else begin
        m_valid = if_valid;
        m_ctrl  = if_valid ? f_ctrl(if_instr) : 8'h00;
        m_instr = if_instr;
        m_pc    = if_pc;
        m_imm   = f_imm(if_instr);
        m_rd    = if_instr[11:7];
        m_known = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("valid", idex_valid, m_valid);
      chk("ctrl", idex_ctrl, m_ctrl);
      chk("id_stall", id_stall, f_stall());
      chk("rs1", id_rs1, if_instr[19:15]);
      chk("rs2", id_rs2, if_instr[24:20]);
      if (m_known) begin
        chk("instr", idex_instr, m_instr);
        chk("pc", idex_pc, m_pc);
        chk("imm", idex_imm, m_imm);
        chk("rd", idex_rd, m_rd);
      end
`ifdef ID_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_sc);
      chk("bubble_cnt", bubble_cnt, m_bc);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [7:0] pc);
    if_valid = 1; if_instr = ins; if_pc = pc;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    logic [6:0]  ops [6];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 5)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_stall = 0;
    tick();
    rst = 0;
    chk("rst_valid", idex_valid, 0);
    chk("rst_ctrl", idex_ctrl, 0);
    chk("rst_imm", idex_imm, 0);

    // addi x1,x0,5
    put(32'h00500093, 8'h10);
    tick();
    chk("addi_valid", idex_valid, 1);
    chk("addi_ctrl", idex_ctrl, 8'hE1);
    chk("addi_imm", idex_imm, 32'h5);
    chk("addi_rd", idex_rd, 1);
    chk("addi_stall", id_stall, 0);

    // lw x2,0(x1) then add x3,x2,x2
    put(32'h0000A103, 8'h14);
    tick();
    put(32'h002101B3, 8'h18);
    #1 chk("lu_stall", id_stall, 1);
    tick();
    chk("lu_bub_valid", idex_valid, 0);
    chk("lu_bub_ctrl", idex_ctrl, 0);
    tick();
    chk("add_ctrl", idex_ctrl, 8'h41);
    chk("add_rd", idex_rd, 3);
`ifdef ID_PERF_CNT_EN
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_bubble_cnt", bubble_cnt, 1);
`endif

    put(32'hFE000EE3, 8'h1C);
    tick();
    chk("beq_ctrl", idex_ctrl, 8'h30);
    chk("beq_imm", idex_imm, 32'hFFFFFFFC);
    put(32'h0020A423, 8'h20);
    tick();
    chk("sw_ctrl", idex_ctrl, 8'h84);
    chk("sw_imm", idex_imm, 32'h8);

    // EX hold for three cycles
    ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      put(rnd_instr(), 8'(8'h40 + k));
      #1 chk("hold_stall", id_stall, 1);
      tick();
      chk("hold_ctrl", idex_ctrl, 8'h84);
      chk("hold_imm", idex_imm, 32'h8);
      chk("hold_pc", idex_pc, 8'h20);
    end
    ex_stall = 0;
    put(32'h00500093, 8'h24);
    tick();
    chk("release_ctrl", idex_ctrl, 8'hE1);
    chk("release_pc", idex_pc, 8'h24);

    // flush beats ex_stall and load-use
    put(32'h0000A103, 8'h28);
    tick();
    put(32'h002101B3, 8'h2C);
    flush = 1; ex_stall = 1;
    #1 chk("flush_stall", id_stall, 1);
    tick();
    flush = 0; ex_stall = 0;
    chk("flush_valid", idex_valid, 0);
    chk("flush_ctrl", idex_ctrl, 0);
    put(32'h0000007F, 8'h30);
    #1 chk("unk_stall", id_stall, 0);
    tick();
    chk("unk_valid", idex_valid, 1);
    chk("unk_ctrl", idex_ctrl, 0);
    chk("unk_imm", idex_imm, 0);

    // reset during load-use stall
    put(32'h0000A103, 8'h34);
    tick();
    put(32'h002101B3, 8'h38);
    #1 chk("pre_rst_stall", id_stall, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_valid", idex_valid, 0);
    chk("rst2_ctrl", idex_ctrl, 0);
    chk("rst2_instr", idex_instr, 0);
    chk("rst2_pc", idex_pc, 0);
    chk("rst2_imm", idex_imm, 0);
    chk("rst2_rd", idex_rd, 0);
    chk("rst2_stall", id_stall, 0);

    // random traffic; IF/ID holds its instruction whenever ID stalled
    for (int n = 0; n < 3000; n++) begin
      if (n == 0 || !f_stall()) begin
        if_valid = ($urandom_range(0, 7) != 0);
        if_instr = rnd_instr();
        if_pc    = 8'($urandom);
      end
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 0; flush = 0; ex_stall = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
